lcd_timing_gen: RTL and testbench



---
 rtl/lcd_timing_pkg.sv | 34 +++
 rtl/lcd_timing_gen_if.sv | 33 +++
 rtl/lcd_axis_counter.sv | 50 +++++
 rtl/lcd_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_pkg
// Description : Default 800x480 panel timing constants, counter widths and a
//               small window-compare helper shared by the timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_timing_pkg;

  // Counter widths for column (0..1055) and row (0..524)
  localparam int COL_W = 11;
  localparam int FIL_W = 10;

  // Default horizontal timing, in NCLK periods
  localparam int DEF_H_TOTAL     = 1056;
  localparam int DEF_H_SYNC      = 1;
  localparam int DEF_H_ACT_START = 216;
  localparam int DEF_H_ACT       = 800;

  // Default vertical timing, in lines
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 1;
  localparam int DEF_V_ACT_START = 35;
  localparam int DEF_V_ACT       = 480;

  // Unsigned half-open window test: lo <= v < hi
  function automatic logic in_window(input logic [15:0] v,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_gen_if
// Description : Panel timing bundle between the timing generator (master) and
//               the rendering stage (slave). frame/frame_start exist only when
//               LCD_FRAME_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_timing_gen_if;
  import lcd_timing_pkg::*;

  logic             NCLK;
  logic             GREST;
  logic             HD;
  logic             VD;
  logic             DEN;
  logic [COL_W-1:0] col;
  logic [FIL_W-1:0] fil;
`ifdef LCD_FRAME_COUNT_EN
  logic [7:0]       frame;
  logic             frame_start;
`endif

`ifdef LCD_FRAME_COUNT_EN
  modport master (output NCLK, GREST, HD, VD, DEN, col, fil, frame, frame_start);
  modport slave  (input  NCLK, GREST, HD, VD, DEN, col, fil, frame, frame_start);
`else
  modport master (output NCLK, GREST, HD, VD, DEN, col, fil);
  modport slave  (input  NCLK, GREST, HD, VD, DEN, col, fil);
`endif

endinterface
`default_nettype wire

// File: rtl/lcd_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_axis_counter
// Description : Wrapping up-counter 0..MAX with enable. Exposes the registered
//               count, the value it will take on the next edge, and a wrap
//               strobe (enabled and currently at MAX).
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_axis_counter #(
  parameter int W   = 11,
  parameter int MAX = 1055
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_cnt_nxt,
  output logic         o_wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max;

  // Next count: hold, increment, or wrap back to zero after MAX
  always_comb begin
    at_max = (cnt_q == MAX_V);
    cnt_d  = cnt_q;
    if (i_en) begin
      cnt_d = at_max ? '0 : cnt_q + W'(1);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt     = cnt_q;
  assign o_cnt_nxt = cnt_d;
  assign o_wrap    = i_en && at_max;

endmodule
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_gen
// Description : LCD panel timing generator. Divides CLK by two into NCLK and
//               advances col/fil on the CLK edge where NCLK falls, so every
//               output is stable across posedge NCLK. HD/VD/DEN are registered
//               from the next counter values to stay aligned with col/fil.
//               GREST is RST_n re-synchronised to CLK.
//               Optional: LCD_FRAME_COUNT_EN adds frame and frame_start.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_ACT_START = DEF_H_ACT_START,
  parameter int H_ACT       = DEF_H_ACT,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_ACT_START = DEF_V_ACT_START,
  parameter int V_ACT       = DEF_V_ACT
) (
  input  logic                CLK,
  input  logic                RST_n,
  lcd_timing_gen_if.master    lcd
);

  localparam logic [COL_W-1:0] H_SYNC_W = COL_W'(H_SYNC);
  localparam logic [FIL_W-1:0] V_SYNC_W = FIL_W'(V_SYNC);
  localparam logic [15:0]      H_LO     = 16'(H_ACT_START);
  localparam logic [15:0]      H_HI     = 16'(H_ACT_START + H_ACT);
  localparam logic [15:0]      V_LO     = 16'(V_ACT_START);
  localparam logic [15:0]      V_HI     = 16'(V_ACT_START + V_ACT);

  logic             nclk_q;
  logic             nclk_d;
  logic [1:0]       grest_sync_q;
  logic [1:0]       grest_sync_d;
  logic             advance;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_nxt;
  logic [FIL_W-1:0] fil_q;
  logic [FIL_W-1:0] fil_nxt;
  logic             col_wrap;
  logic             fil_wrap;
  logic             hd_q;
  logic             hd_d;
  logic             vd_q;
  logic             vd_d;
  logic             den_q;
  logic             den_d;

  // The edge on which NCLK goes 1->0 is the only one that moves the raster
  assign advance = nclk_q;

  lcd_axis_counter #(
    .W   (COL_W),
    .MAX (H_TOTAL - 1)
  ) u_col_cnt (
    .clk       (CLK),
    .rst_n     (RST_n),
    .i_en      (advance),
    .o_cnt     (col_q),
    .o_cnt_nxt (col_nxt),
    .o_wrap    (col_wrap)
  );

  // col_wrap already implies advance
  lcd_axis_counter #(
    .W   (FIL_W),
    .MAX (V_TOTAL - 1)
  ) u_fil_cnt (
    .clk       (CLK),
    .rst_n     (RST_n),
    .i_en      (col_wrap),
    .o_cnt     (fil_q),
    .o_cnt_nxt (fil_nxt),
    .o_wrap    (fil_wrap)
  );

  // Pixel clock toggle, GREST shift-in, and sync/enable decode from next counts
  always_comb begin
    nclk_d       = ~nclk_q;
    grest_sync_d = {grest_sync_q[0], 1'b1};
    hd_d         = hd_q;
    vd_d         = vd_q;
    den_d        = den_q;
    if (advance) begin
      hd_d  = !(col_nxt < H_SYNC_W);
      vd_d  = !(fil_nxt < V_SYNC_W);
      den_d = in_window(16'(col_nxt), H_LO, H_HI) &&
              in_window(16'(fil_nxt), V_LO, V_HI);
    end
  end

  // Pixel clock and sync/enable registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      nclk_q <= 1'b0;
      hd_q   <= 1'b1;
      vd_q   <= 1'b1;
      den_q  <= 1'b0;
    end else begin
      nclk_q <= nclk_d;
      hd_q   <= hd_d;
      vd_q   <= vd_d;
      den_q  <= den_d;
    end
  end

  // Two-flop reset synchroniser: asserts at once, releases two CLK edges later
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      grest_sync_q <= 2'b00;
    end else begin
      grest_sync_q <= grest_sync_d;
    end
  end

  assign lcd.NCLK  = nclk_q;
  assign lcd.GREST = grest_sync_q[1];
  assign lcd.HD    = hd_q;
  assign lcd.VD    = vd_q;
  assign lcd.DEN   = den_q;
  assign lcd.col   = col_q;
  assign lcd.fil   = fil_q;

`ifdef LCD_FRAME_COUNT_EN
  logic [7:0] frame_q;
  logic [7:0] frame_d;
  logic       frame_start_q;
  logic       frame_start_d;

  // Count completed frames and flag the first raster position of each frame
  always_comb begin
    frame_d       = frame_q;
    frame_start_d = frame_start_q;
    if (fil_wrap) begin
      frame_d = frame_q + 8'd1;
    end
    if (advance) begin
      frame_start_d = (col_nxt == '0) && (fil_nxt == '0);
    end
  end

  // Frame counter registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      frame_q       <= 8'd0;
      frame_start_q <= 1'b0;
    end else begin
      frame_q       <= frame_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign lcd.frame       = frame_q;
  assign lcd.frame_start = frame_start_q;
`else
  logic fil_wrap_unused;
  assign fil_wrap_unused = fil_wrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_timing_gen
// Description : Scoreboard bench for lcd_timing_gen using a reduced raster so
//               several frames (and, with LCD_FRAME_COUNT_EN, a frame-counter
//               wrap) fit in a short run. Expected outputs come from elapsed
//               CLK edges since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_gen;

  localparam int H_TOTAL     = 10;
  localparam int H_SYNC      = 1;
  localparam int H_ACT_START = 3;
  localparam int H_ACT       = 5;
  localparam int V_TOTAL     = 7;
  localparam int V_SYNC      = 2;
  localparam int V_ACT_START = 3;
  localparam int V_ACT       = 3;
  localparam int FRAME_ADV   = H_TOTAL * V_TOTAL;
  localparam int MID_RST     = 5 + 2 * FRAME_ADV * 3 + 77;
  localparam int RAND_LIMIT  = 1000;
`ifdef LCD_FRAME_COUNT_EN
  localparam int NCYC        = 37500;
`else
  localparam int NCYC        = 3000;
`endif

  typedef struct packed {
    logic        nclk;
    logic        grest;
    logic        hd;
    logic        vd;
    logic        den;
    logic [10:0] col;
    logic [9:0]  fil;
    logic [7:0]  frame;
    logic        fs;
  } exp_t;

  logic CLK;
  logic RST_n;
  lcd_timing_gen_if lcd();

  lcd_timing_gen #(
    .H_TOTAL     (H_TOTAL),
    .H_SYNC      (H_SYNC),
    .H_ACT_START (H_ACT_START),
    .H_ACT       (H_ACT),
    .V_TOTAL     (V_TOTAL),
    .V_SYNC      (V_SYNC),
    .V_ACT_START (V_ACT_START),
    .V_ACT       (V_ACT)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .lcd   (lcd)
  );

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   done   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: k = CLK posedges seen with RST_n high since the last release.
  // Every second edge is one raster step; position is a plain index into the
  // frame, split into column and line by division.
  function automatic exp_t model(input bit in_reset, input int k);
    exp_t e;
    int   adv;
    int   pos;
    int   c;
    int   f;
    e    = '0;
    e.hd = 1'b1;
    e.vd = 1'b1;
    if (in_reset) return e;
    adv     = k / 2;
    pos     = adv % FRAME_ADV;
    c       = pos % H_TOTAL;
    f       = pos / H_TOTAL;
    e.nclk  = (k % 2) == 1;
    e.grest = k >= 2;
    e.col   = 11'(c);
    e.fil   = 10'(f);
    if (adv > 0) begin
      e.hd    = c >= H_SYNC;
      e.vd    = f >= V_SYNC;
      e.den   = (c >= H_ACT_START) && (c < H_ACT_START + H_ACT) &&
                (f >= V_ACT_START) && (f < V_ACT_START + V_ACT);
      e.frame = 8'((adv / FRAME_ADV) % 256);
      e.fs    = pos == 0;
    end
    return e;
  endfunction

  // Stimulus: reset sequencing (initial, one fixed mid-frame, random pulses)
  initial begin
    int k;
    int rst_left;
    k        = 0;
    rst_left = 0;
    RST_n    = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge CLK);
      if (c < 5) begin
        RST_n = 1'b0;
      end else if (rst_left > 0) begin
        RST_n = 1'b0;
        rst_left--;
      end else if (c == MID_RST) begin
        RST_n    = 1'b0;
        rst_left = 2;
      end else if (c < RAND_LIMIT && $urandom_range(0, 399) == 0) begin
        RST_n    = 1'b0;
        rst_left = $urandom_range(0, 4);
      end else begin
        RST_n = 1'b1;
      end
      if (!RST_n) k = 0;
      exp_q.push_back(model(!RST_n, k));
      @(posedge CLK);
      if (RST_n) k++;
    end
    done = 1'b1;
    @(negedge CLK);
    #5;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Monitor: sample mid-low-phase of CLK and compare against the scoreboard
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() == 0) begin
        if (!done) begin
          n_vec++;
          n_miss++;
          $display("FAIL underflow: monitor found no expected vector at %0t", $time);
        end
      end else begin
        e       = exp_q.pop_front();
        a       = '0;
        a.nclk  = lcd.NCLK;
        a.grest = lcd.GREST;
        a.hd    = lcd.HD;
        a.vd    = lcd.VD;
        a.den   = lcd.DEN;
        a.col   = lcd.col;
        a.fil   = lcd.fil;
`ifdef LCD_FRAME_COUNT_EN
        a.frame = lcd.frame;
        a.fs    = lcd.frame_start;
`else
        e.frame = '0;
        e.fs    = 1'b0;
`endif
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL vec%0d t=%0t: got nclk=%b grest=%b hd=%b vd=%b den=%b col=%0d fil=%0d frame=%0d fs=%b ; want nclk=%b grest=%b hd=%b vd=%b den=%b col=%0d fil=%0d frame=%0d fs=%b",
                   n_vec, $time, a.nclk, a.grest, a.hd, a.vd, a.den, a.col, a.fil, a.frame, a.fs,
                   e.nclk, e.grest, e.hd, e.vd, e.den, e.col, e.fil, e.frame, e.fs);
        end
      end
    end
  end

endmodule
`default_nettype wire
